// File: rtl/sem51_bridge.sv
// sem51_bridge: asynchronous 8051-style external-memory bus (SEM) to
// Avalon-MM master bridge, with per-channel interrupt conditioning.
// The MCU strobes are synchronized, then one Avalon transaction is run per
// strobe assertion. SEM_WAITN stretches the MCU cycle until the Avalon side
// has finished or timed out.
module sem51_bridge #(
    parameter int                 AV_DW     = 8,
    parameter int                 ADDR_W    = 13,
    parameter int                 IRQ_N     = 7,
    parameter logic [IRQ_N-1:0]   IRQ_EDGE  = {IRQ_N{1'b0}},
    parameter int                 IRQ_PULSE = 4,
    parameter int                 TIMEOUT   = 255
) (
    input  logic                  csi_clockreset_clk,
    input  logic                  csi_clockreset_reset_n,
    inout  wire  [15:0]           SEM_DATA,
    input  logic [ADDR_W-1:0]     SEM_ADDR,
    input  logic                  SEM_CSN,
    input  logic                  SEM_WEN,
    input  logic                  SEM_OEN,
    output wire                   SEM_WAITN,
    output logic [IRQ_N-1:0]      SEM_INT,
    output logic [ADDR_W-1:0]     avm_m0_address,
    output logic [AV_DW-1:0]      avm_m0_writedata,
    output logic                  avm_m0_write_n,
    output logic                  avm_m0_read_n,
    output logic                  avm_m0_chipselect_n,
    input  logic [AV_DW-1:0]      avm_m0_readdata,
    input  logic                  avm_m0_waitrequest_n,
    input  logic [IRQ_N-1:0]      irq_in,
    output logic                  timeout_flag
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    logic clk;
    logic rst_n;
    assign clk   = csi_clockreset_clk;
    assign rst_n = csi_clockreset_reset_n;

    // Strobe synchronizers, bit order {oen, wen, csn}
    logic [2:0]  strb_meta_reg;
    logic [2:0]  strb_sync_reg;
    logic        wr_req;
    logic        rd_req;

    state_t      state_reg;
    state_t      state_next;

    logic        is_wr_reg;
    logic        is_wr_next;
    logic [ADDR_W-1:0] addr_next;
    logic [AV_DW-1:0]  wdata_next;
    logic [AV_DW-1:0]  rdata_reg;
    logic [AV_DW-1:0]  rdata_next;
    logic [15:0] tmo_cnt_reg;
    logic [15:0] tmo_cnt_next;
    logic        tmo_flag_next;
    logic        tmo_hit;
    logic        cs_n_next;
    logic        write_n_next;
    logic        read_n_next;

    logic        sem_wait_low;
    logic        sem_data_oe;
    logic [15:0] rdata_ext;
    logic        sem_data_unused;

    // Two-stage synchronizers for the asynchronous MCU strobes (idle high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strb_meta_reg <= 3'b111;
            strb_sync_reg <= 3'b111;
        end else begin
            strb_meta_reg <= {SEM_OEN, SEM_WEN, SEM_CSN};
            strb_sync_reg <= strb_meta_reg;
        end
    end

    assign wr_req  = !strb_sync_reg[0] && !strb_sync_reg[1];
    assign rd_req  = !strb_sync_reg[0] && !strb_sync_reg[2];

    // Abort on the first ACCESS clock that completes the TIMEOUT-long stall
    assign tmo_hit = !avm_m0_waitrequest_n && (tmo_cnt_reg == TMO_LAST);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic; DONE waits for the strobes to be released
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (wr_req || rd_req) state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_ACCESS;
            ST_ACCESS:  if (avm_m0_waitrequest_n || tmo_hit) state_next = ST_DONE;
            ST_DONE:    if (!wr_req && !rd_req) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered Avalon side and datapath
    always_comb begin
        is_wr_next    = is_wr_reg;
        addr_next     = avm_m0_address;
        wdata_next    = avm_m0_writedata;
        rdata_next    = rdata_reg;
        tmo_cnt_next  = tmo_cnt_reg;
        tmo_flag_next = timeout_flag;
        if (state_reg == ST_CAPTURE) begin
            // Write wins when both strobes are active
            is_wr_next   = wr_req;
            addr_next    = SEM_ADDR;
            wdata_next   = SEM_DATA[AV_DW-1:0];
            tmo_cnt_next = '0;
        end
        if (state_reg == ST_ACCESS) begin
            if (avm_m0_waitrequest_n) begin
                if (!is_wr_reg) rdata_next = avm_m0_readdata;
            end else if (tmo_hit) begin
                rdata_next    = '1;
                tmo_flag_next = 1'b1;
            end else begin
                tmo_cnt_next = tmo_cnt_reg + 16'd1;
            end
        end
        // Strobes are low exactly while the FSM sits in ACCESS
        cs_n_next    = (state_next != ST_ACCESS);
        write_n_next = !((state_next == ST_ACCESS) && is_wr_next);
        read_n_next  = !((state_next == ST_ACCESS) && !is_wr_next);
    end

    // Registered Avalon outputs, read-data latch and timeout tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_wr_reg           <= 1'b0;
            avm_m0_address      <= '0;
            avm_m0_writedata    <= '0;
            avm_m0_chipselect_n <= 1'b1;
            avm_m0_write_n      <= 1'b1;
            avm_m0_read_n       <= 1'b1;
            rdata_reg           <= '0;
            tmo_cnt_reg         <= '0;
            timeout_flag        <= 1'b0;
        end else begin
            is_wr_reg           <= is_wr_next;
            avm_m0_address      <= addr_next;
            avm_m0_writedata    <= wdata_next;
            avm_m0_chipselect_n <= cs_n_next;
            avm_m0_write_n      <= write_n_next;
            avm_m0_read_n       <= read_n_next;
            rdata_reg           <= rdata_next;
            tmo_cnt_reg         <= tmo_cnt_next;
            timeout_flag        <= tmo_flag_next;
        end
    end

    // Zero-extend read data onto the 16-bit MCU bus
    always_comb begin
        rdata_ext              = '0;
        rdata_ext[AV_DW-1:0]   = rdata_reg;
    end

    // Wait is combinational on the raw pins so it is low before the MCU samples it
    assign sem_wait_low = rst_n && !SEM_CSN && (!SEM_WEN || !SEM_OEN) && (state_reg != ST_DONE);
    assign SEM_WAITN    = sem_wait_low ? 1'b0 : 1'bz;

    assign sem_data_oe  = !SEM_CSN && !SEM_OEN && SEM_WEN && (state_reg == ST_DONE);
    assign SEM_DATA     = sem_data_oe ? rdata_ext : 16'hzzzz;

    // Upper data bits are don't-care on writes
    assign sem_data_unused = ^SEM_DATA;

    // Interrupt conditioning, one instance per channel
    genvar gi;
    generate
        for (gi = 0; gi < IRQ_N; gi++) begin : g_irq
            if (IRQ_EDGE[gi]) begin : g_edge
                logic [2:0] sync_reg;
                logic [7:0] cnt_reg;

                // Two sync stages plus one history stage for edge detection
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        sync_reg <= 3'b111;
                    end else begin
                        sync_reg <= {sync_reg[1:0], irq_in[gi]};
                    end
                end

                // Pulse stretcher: every rising edge (re)loads the full length
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        cnt_reg <= '0;
                    end else if (sync_reg[1] && !sync_reg[2]) begin
                        cnt_reg <= 8'(IRQ_PULSE);
                    end else if (cnt_reg != 8'd0) begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end

                assign SEM_INT[gi] = (cnt_reg != 8'd0);
            end else begin : g_level
                logic lvl_reg;

                // Level channel: single register stage
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        lvl_reg <= 1'b0;
                    end else begin
                        lvl_reg <= irq_in[gi];
                    end
                end

                assign SEM_INT[gi] = lvl_reg;
            end
        end
    endgenerate

endmodule

// File: tb/tb_sem51_bridge.sv
// tb_sem51_bridge: randomized bench for sem51_bridge. An MCU driver issues
// SEM cycles and pushes the expected Avalon access into a queue; a monitor
// pops and compares whenever the bridge starts an Avalon cycle. Interrupt
// outputs are compared against a history-based model of the pulse rules.
module tb_sem51_bridge;

    localparam int               AV_DW     = 8;
    localparam int               ADDR_W    = 13;
    localparam int               IRQ_N     = 7;
    localparam logic [IRQ_N-1:0] IRQ_EDGE  = 7'b0010101;
    localparam int               IRQ_PULSE = 4;
    localparam int               TIMEOUT   = 8;

    typedef struct {
        bit         wr;
        logic [12:0] addr;
        logic [7:0]  wdata;
        int          len;     // expected strobe length, -1 = aborted by reset
    } av_item_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    wire  [15:0] sem_data;
    logic [15:0] mcu_wdata = '0;
    logic        mcu_drive = 1'b0;
    logic [12:0] sem_addr = '0;
    logic        sem_csn = 1'b1;
    logic        sem_wen = 1'b1;
    logic        sem_oen = 1'b1;
    wire         sem_waitn;
    logic [IRQ_N-1:0] sem_int;
    logic [IRQ_N-1:0] irq_in = '0;
    logic [12:0] avm_address;
    logic [7:0]  avm_writedata;
    logic [7:0]  avm_readdata = '0;
    logic        avm_write_n;
    logic        avm_read_n;
    logic        avm_cs_n;
    logic        avm_waitrequest_n = 1'b0;
    logic        timeout_flag;

    int vectors = 0;
    int miscompares = 0;
    bit exp_tmo_flag = 1'b0;

    av_item_t av_exp_q[$];
    logic [IRQ_N-1:0] irq_hist[$];

    int          slave_ws = 0;
    int          slave_cnt = 0;
    logic [7:0]  slave_rdata = '0;

    always #5 clk = ~clk;

    assign sem_data = mcu_drive ? mcu_wdata : 16'hzzzz;
    pullup (sem_waitn);

    sem51_bridge #(
        .AV_DW     (AV_DW),
        .ADDR_W    (ADDR_W),
        .IRQ_N     (IRQ_N),
        .IRQ_EDGE  (IRQ_EDGE),
        .IRQ_PULSE (IRQ_PULSE),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .csi_clockreset_clk     (clk),
        .csi_clockreset_reset_n (rst_n),
        .SEM_DATA               (sem_data),
        .SEM_ADDR               (sem_addr),
        .SEM_CSN                (sem_csn),
        .SEM_WEN                (sem_wen),
        .SEM_OEN                (sem_oen),
        .SEM_WAITN              (sem_waitn),
        .SEM_INT                (sem_int),
        .avm_m0_address         (avm_address),
        .avm_m0_writedata       (avm_writedata),
        .avm_m0_write_n         (avm_write_n),
        .avm_m0_read_n          (avm_read_n),
        .avm_m0_chipselect_n    (avm_cs_n),
        .avm_m0_readdata        (avm_readdata),
        .avm_m0_waitrequest_n   (avm_waitrequest_n),
        .irq_in                 (irq_in),
        .timeout_flag           (timeout_flag)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Avalon slave: holds waitrequest_n low for slave_ws clocks of each cycle
    always @(negedge clk) begin
        if (!avm_cs_n) begin
            avm_waitrequest_n = (slave_cnt >= slave_ws);
            avm_readdata      = (slave_cnt >= slave_ws) ? slave_rdata : ~slave_rdata;
            slave_cnt++;
        end else begin
            slave_cnt         = 0;
            avm_waitrequest_n = 1'b0;
            avm_readdata      = 8'($urandom);
        end
    end

    // Avalon monitor: pops one expected access per cycle start
    bit       mon_active = 1'b0;
    bit       mon_have = 1'b0;
    int       mon_len = 0;
    av_item_t mon_cur;
    always @(negedge clk) begin
        if (!avm_cs_n) begin
            if (!mon_active) begin
                mon_active = 1'b1;
                mon_len    = 0;
                check("av_cycle_expected", 32'(av_exp_q.size() != 0), 32'd1);
                if (av_exp_q.size() != 0) begin
                    mon_cur  = av_exp_q.pop_front();
                    mon_have = 1'b1;
                    check("av_dir_wn_rn", 32'({avm_write_n, avm_read_n}), mon_cur.wr ? 32'd1 : 32'd2);
                    check("av_addr", 32'(avm_address), 32'(mon_cur.addr));
                    if (mon_cur.wr) check("av_wdata", 32'(avm_writedata), 32'(mon_cur.wdata));
                end else begin
                    mon_have = 1'b0;
                end
            end
            mon_len++;
        end else if (mon_active) begin
            mon_active = 1'b0;
            if (mon_have && mon_cur.len >= 0) check("av_strobe_clks", 32'(mon_len), 32'(mon_cur.len));
        end
    end

    // Expected SEM_INT after clock n from the sampled irq_in history
    function automatic logic [IRQ_N-1:0] irq_expect(input int n);
        logic [IRQ_N-1:0] e;
        logic cur, prev;
        e = '0;
        for (int i = 0; i < IRQ_N; i++) begin
            if (!IRQ_EDGE[i]) begin
                e[i] = irq_hist[n][i];
            end else begin
                // High for IRQ_PULSE clocks starting 2 clocks after a sampled rise
                for (int k = n - IRQ_PULSE - 1; k <= n - 2; k++) begin
                    if (k >= 0) begin
                        cur  = irq_hist[k][i];
                        prev = (k > 0) ? irq_hist[k-1][i] : 1'b0;
                        if (cur && !prev) e[i] = 1'b1;
                    end
                end
            end
        end
        return e;
    endfunction

    task automatic irq_sequence();
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            irq_hist.push_back(irq_in);
            @(negedge clk);
            check("sem_int", 32'(sem_int), 32'(irq_expect(c)));
            if (c < 12) begin
                irq_in = (c == 2 || c == 4) ? 7'b0000100 : 7'b0000000;
            end else begin
                for (int i = 0; i < IRQ_N; i++)
                    if ($urandom_range(0, 4) == 0) irq_in[i] = ~irq_in[i];
            end
        end
        irq_in = '0;
    endtask

    // One MCU cycle: expected Avalon access goes to the scoreboard queue
    task automatic mcu_txn(input bit do_wr, input bit do_rd, input logic [12:0] addr,
                           input logic [15:0] data, input int ws, input logic [7:0] rdval,
                           input int hold);
        av_item_t it;
        bit tmo;
        int len, lat, acc_start;
        tmo      = (ws >= TIMEOUT);
        len      = tmo ? TIMEOUT : ws + 1;
        it.wr    = do_wr;
        it.addr  = addr;
        it.wdata = data[7:0];
        it.len   = len;
        av_exp_q.push_back(it);
        slave_ws    = ws;
        slave_rdata = rdval;
        @(negedge clk);
        sem_addr  = addr;
        mcu_wdata = data;
        mcu_drive = do_wr;
        sem_wen   = !do_wr;
        sem_oen   = !do_rd;
        sem_csn   = 1'b0;
        #1;
        check("waitn_asserted", 32'(sem_waitn), 32'd0);
        lat = 0;
        acc_start = -1;
        while (sem_waitn !== 1'b1 && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
            if (acc_start < 0 && !avm_cs_n) acc_start = lat;
        end
        check("av_start_clks", 32'(acc_start), 32'd4);
        check("waitn_release_clks", 32'(lat), 32'(4 + len));
        if (tmo) exp_tmo_flag = 1'b1;
        if (do_rd && !do_wr) check("sem_rdata", 32'(sem_data), 32'({8'h00, tmo ? 8'hFF : rdval}));
        check("timeout_flag", 32'(timeout_flag), 32'(exp_tmo_flag));
        repeat (hold) @(negedge clk);
        check("waitn_hold_released", 32'(sem_waitn), 32'd1);
        @(negedge clk);
        sem_csn   = 1'b1;
        sem_wen   = 1'b1;
        sem_oen   = 1'b1;
        mcu_drive = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic sem_sequence();
        int kind, ws;
        mcu_txn(1'b1, 1'b0, 13'h00A5, 16'h003C, 0, 8'h00, 0);
        mcu_txn(1'b0, 1'b1, 13'h0123, 16'h0000, 3, 8'h5A, 1);
        mcu_txn(1'b0, 1'b1, 13'h00F0, 16'h0000, 300, 8'h11, 2);
        mcu_txn(1'b1, 1'b1, 13'h1ABC, 16'hBEEF, 1, 8'h00, 8);
        mcu_txn(1'b0, 1'b1, 13'h0042, 16'h0000, TIMEOUT - 1, 8'h96, 0);
        mcu_txn(1'b0, 1'b1, 13'h1FFF, 16'h0000, TIMEOUT, 8'h69, 0);
        for (int t = 0; t < 30; t++) begin
            kind = int'($urandom_range(0, 2));
            ws   = ($urandom_range(0, 5) == 0) ? 300 : int'($urandom_range(0, 3));
            mcu_txn(kind != 1, kind != 0, 13'($urandom), 16'($urandom), ws,
                    8'($urandom), int'($urandom_range(0, 3)));
        end
    endtask

    // Reset in the middle of ACCESS, then restart with the read strobe still held
    task automatic reset_test();
        av_item_t it;
        int lat, acc_start;
        it.wr    = 1'b0;
        it.addr  = 13'h0777;
        it.wdata = '0;
        it.len   = -1;
        av_exp_q.push_back(it);
        slave_ws    = 300;
        slave_rdata = 8'h33;
        @(negedge clk);
        sem_addr = 13'h0777;
        sem_wen  = 1'b1;
        sem_oen  = 1'b0;
        sem_csn  = 1'b0;
        lat = 0;
        while (avm_cs_n && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("rst_av_started", 32'(avm_cs_n), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_abort_strobes", 32'({avm_cs_n, avm_write_n, avm_read_n}), 32'h7);
        check("rst_waitn_z", 32'(sem_waitn), 32'd1);
        check("rst_flag_clear", 32'(timeout_flag), 32'd0);
        check("rst_int_clear", 32'(sem_int), 32'd0);
        exp_tmo_flag = 1'b0;
        it.len       = 3;
        av_exp_q.push_back(it);
        slave_ws     = 2;
        slave_rdata  = 8'hC5;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_waitn_held", 32'(sem_waitn), 32'd0);
        lat = 0;
        acc_start = -1;
        while (sem_waitn !== 1'b1 && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
            if (acc_start < 0 && !avm_cs_n) acc_start = lat;
        end
        check("rst_new_start_clks", 32'(acc_start), 32'd4);
        check("rst_waitn_release_clks", 32'(lat), 32'd7);
        check("rst_sem_rdata", 32'(sem_data), 32'h00C5);
        check("rst_timeout_flag", 32'(timeout_flag), 32'(exp_tmo_flag));
        @(negedge clk);
        sem_csn = 1'b1;
        sem_oen = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_strobes", 32'({avm_cs_n, avm_write_n, avm_read_n}), 32'h7);
        check("reset_address", 32'(avm_address), 32'd0);
        check("reset_writedata", 32'(avm_writedata), 32'd0);
        check("reset_timeout_flag", 32'(timeout_flag), 32'd0);
        check("reset_sem_int", 32'(sem_int), 32'd0);
        sem_csn = 1'b0;
        sem_oen = 1'b0;
        #1;
        check("reset_waitn_z", 32'(sem_waitn), 32'd1);
        sem_csn = 1'b1;
        sem_oen = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        fork
            sem_sequence();
            irq_sequence();
        join
        reset_test();
        check("av_queue_empty", 32'(av_exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
